// File: rtl/serial_frame_deser_pkg.sv
// Shared definitions for the serial frame receiver and its future serializer
// counterpart: FSM state encodings, line-level constants, sizing helper.
package serial_frame_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Level the line rests at between frames, also the required stop level.
    localparam logic LINE_IDLE = 1'b1;
    // Level that opens a frame.
    localparam logic START_BIT = 1'b0;

    // Width of the data-bit counter: enough to hold n-1, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/serial_frame_deser_word_hold_reg.sv
// One-entry valid/ready holding register. A completed frame is loaded when the
// slot is empty or being drained this same edge; otherwise the frame is dropped
// and a one-cycle overrun pulse is raised.
module word_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_err,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic              slot_free;

    assign slot_free = !valid_q || ready;

    // Next-state: drain on handshake, then let a new word overwrite the slot
    // on the same edge so back-to-back words keep valid high without a bubble.
    always_comb begin
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (slot_free) begin
                data_d  = load_data;
                err_d   = load_err;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Holding register state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity, stop bit. Finished words (good or bad) go to a one-entry holding
// register with a valid/ready port.
module serial_frame_deser
    import serial_frame_deser_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned     CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] shreg_shift;
    logic              deliver;
    logic              word_err;

    // Frame sequencing: next state, shift register, counter and parity flag.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        perr_d      = perr_q;
        deliver     = 1'b0;
        word_err    = perr_q;
        // Right shift with the new bit entering at the MSB; written this way
        // so it also holds for a one-bit word.
        shreg_shift = shreg_q >> 1;
        shreg_shift[DATA_W-1] = in;
        case (state_q)
            ST_IDLE: begin
                if (in == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            ST_DATA: begin
                shreg_d = shreg_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                perr_d  = PARITY_EN ? ((^shreg_q) ^ in) : 1'b0;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                // A low stop bit only flags the word; it never opens a frame.
                deliver  = 1'b1;
                word_err = perr_q | (in != LINE_IDLE);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receiver state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    word_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (deliver),
        .load_data(shreg_q),
        .load_err (word_err),
        .ready    (ready),
        .data     (data),
        .valid    (valid),
        .err      (err),
        .overrun  (overrun)
    );

endmodule
